// File: rtl/vedic_mul_seq_ctrl.sv
// Sequencing controller for a time-shared Vedic multiplier.
// A single (N/2)x(N/2) Urdhva-Tiryagbhyam unit is scheduled over four
// cycles (PP0..PP3) to build an NxN unsigned product by shift-accumulate.
// Optional feature macro: VEDIC_SEQ_ZERO_SKIP_EN. When it is defined, a start
// with a zero operand completes in one cycle and bypasses the multiplier.
//
// Handshake: start is sampled only on edges where busy=0 (IDLE or DONE).
// An accepted start captures a/b. While busy=1 both start and a/b are ignored,
// and start is never queued. done is a one-cycle pulse that coincides with p
// holding the new product. p keeps that value until the next completion.

// Combinational HxH Urdhva-Tiryagbhyam (vertical and crosswise) multiplier.
// Bit products come from NAND/NOR cells. Each output column sums its crosswise
// bit products plus the carry from the column below it.
module vedic_uth_mul #(
  parameter int H = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] prod
);
  localparam int W = 2 * H;

  function automatic logic nand2(input logic i0, input logic i1);
    return ~(i0 & i1);
  endfunction

  function automatic logic nor2(input logic i0, input logic i1);
    return ~(i0 | i1);
  endfunction

  // AND built from the gate cells: NOR of the two inverted inputs.
  function automatic logic and_cell(input logic i0, input logic i1);
    return nor2(nand2(i0, i0), nand2(i1, i1));
  endfunction

  logic [W-1:0] col;
  logic [W-1:0] carry;

  // Column-by-column crosswise sums with a ripple carry between columns.
  always_comb begin
    prod  = '0;
    carry = '0;
    col   = '0;
    for (int k = 0; k < 2 * H - 1; k++) begin
      col = carry;
      for (int i = 0; i < H; i++) begin
        for (int j = 0; j < H; j++) begin
          if (i + j == k) begin
            col = col + {{(W-1){1'b0}}, and_cell(x[i], y[j])};
          end
        end
      end
      prod[k] = col[0];
      carry   = col >> 1;
    end
    prod[2*H-1] = carry[0];
  end
endmodule

module vedic_mul_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int H = N / 2;

  // Odd or too-narrow operands cannot be split into two equal halves.
  generate
    if ((N < 2) || ((N % 2) != 0)) begin : g_bad_n
      $error("vedic_mul_seq_ctrl: N must be even and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [2*N-1:0] acc;
  logic           accept;
  logic           zero_op;
  logic [H-1:0]   mul_a;
  logic [H-1:0]   mul_b;
  logic [N-1:0]   mul_p;
  logic [2*N-1:0] pp_ext;
  logic [2*N-1:0] term;

  // A start is only considered while the unit is not busy.
  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  // A zero operand makes the product zero, so the multiplier is not used.
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: a fixed four-step schedule after each accepted start.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = zero_op ? DONE : PP0;
        end else begin
          state_nx = IDLE;
        end
      end
      PP0:     state_nx = PP1;
      PP1:     state_nx = PP2;
      PP2:     state_nx = PP3;
      PP3:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand mux and weight of the partial product, both selected by state.
  // PP0 forms lo*lo, PP1 forms hi(a)*lo(b), PP2 forms lo(a)*hi(b), PP3 forms hi*hi.
  always_comb begin
    mul_a  = a_r[H-1:0];
    mul_b  = b_r[H-1:0];
    pp_ext = {{N{1'b0}}, mul_p};
    term   = pp_ext;
    case (state)
      PP1: begin
        mul_a = a_r[N-1:H];
        term  = pp_ext << H;
      end
      PP2: begin
        mul_b = b_r[N-1:H];
        term  = pp_ext << H;
      end
      PP3: begin
        mul_a = a_r[N-1:H];
        mul_b = b_r[N-1:H];
        term  = pp_ext << N;
      end
      default: begin
        term = pp_ext;
      end
    endcase
  end

  vedic_uth_mul #(.H(H)) u_mul (
    .x    (mul_a),
    .y    (mul_b),
    .prod (mul_p)
  );

  // Operand capture, accumulation and the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      p   <= '0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      if (zero_op) begin
        p <= '0;
      end
    end else begin
      case (state)
        PP0, PP1, PP2: acc <= acc + term;
        PP3:           p   <= acc + term;
        default:       acc <= acc;
      endcase
    end
  end

  // Status flags are registered copies of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == PP0) || (state_nx == PP1) ||
              (state_nx == PP2) || (state_nx == PP3);
      done <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed bench for vedic_mul_seq_ctrl. It drives an N=4 and an N=8 instance.
// The optional macro VEDIC_SEQ_ZERO_SKIP_EN changes the expected zero-operand timing.
module tb_vedic_mul_seq_ctrl;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vedic_mul_seq_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  vedic_mul_seq_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic cur_done(input bit wide);
    return wide ? done8 : done4;
  endfunction

  function automatic logic cur_busy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction

  function automatic logic [15:0] cur_p(input bit wide);
    return wide ? p8 : {8'h00, p4};
  endfunction

  // Issues one start at the current cycle and follows the multiply to its done pulse.
  // Latency counts clock edges from the cycle in which start is asserted.
  // The task returns in the done cycle.
  task automatic mul_op(input bit wide, input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input int exp_busy, input logic [15:0] exp_p,
                        input string tag);
    int  lat;
    int  bc;
    bit  seen;
    if (wide) begin
      start8 = 1'b1; a8 = x; b8 = y;
    end else begin
      start4 = 1'b1; a4 = x[3:0]; b4 = y[3:0];
    end
    tick;
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = ~x[3:0];
    b4 = ~y[3:0];
    a8 = ~x;
    b8 = ~y;
    lat  = 1;
    bc   = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (cur_done(wide)) begin
        seen = 1'b1;
        break;
      end
      if (cur_busy(wide)) bc++;
      tick;
      lat++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, exp_busy);
    check({tag, "_p"}, 32'(cur_p(wide)), 32'(exp_p));
  endtask

  initial begin
    int zl;
    int zb;
    int n_done;
    int done_at;
    logic [7:0]  x, y;
    logic [15:0] e;
    logic [7:0]  p_seen;

    zl = ZERO_SKIP ? 1 : 5;
    zb = ZERO_SKIP ? 0 : 4;

    rst = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    tick;
    tick;
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_done4", 32'(done4), 32'd0);
    check("reset_p4", 32'(p4), 32'd0);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_p8", 32'(p8), 32'd0);
    rst = 1'b0;
    tick;

    // 13*11 = 143 (0x8F)
    mul_op(1'b0, 8'd13, 8'd11, 5, 4, 16'd143, "t1_13x11");
    tick;
    check("t1_done_pulse_low", 32'(done4), 32'd0);
    check("t1_p_hold", 32'(p4), 32'd143);
    check("t1_idle_busy", 32'(busy4), 32'd0);

    // Back-to-back: restart in the DONE cycle.
    mul_op(1'b0, 8'd15, 8'd15, 5, 4, 16'd225, "t2_15x15");
    mul_op(1'b0, 8'd2, 8'd3, 5, 4, 16'd6, "t2_2x3_b2b");
    tick;
    check("t2_done_low", 32'(done4), 32'd0);

    // A start pulse during PP1 must be ignored.
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd9;
    tick;
    n_done = 0;
    done_at = -1;
    p_seen = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      end else begin
        start4 = 1'b0;
      end
      if (done4) begin
        n_done++;
        if (done_at < 0) begin
          done_at = c;
          p_seen = p4;
        end
      end
      tick;
    end
    start4 = 1'b0;
    check("t3_done_count", n_done, 1);
    check("t3_done_at", done_at, 4);
    check("t3_p", 32'(p_seen), 32'd63);
    check("t3_p_hold", 32'(p4), 32'd63);

    // Reset asserted in PP2 abandons the multiply.
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    tick;
    start4 = 1'b0;
    tick;
    tick;
    check("t4_busy_before_rst", 32'(busy4), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy4), 32'd0);
    check("t4_rst_done", 32'(done4), 32'd0);
    check("t4_rst_p", 32'(p4), 32'd0);
    tick;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done4) n_done++;
      tick;
    end
    check("t4_no_done", n_done, 0);
    check("t4_p_zero", 32'(p4), 32'd0);

    // Zero operands: full path or single-cycle skip depending on the macro.
    mul_op(1'b0, 8'd5, 8'd5, 5, 4, 16'd25, "t5_5x5");
    tick;
    mul_op(1'b0, 8'd0, 8'd9, zl, zb, 16'd0, "t5_0x9");
    tick;
    check("t5_done_low", 32'(done4), 32'd0);
    mul_op(1'b0, 8'd3, 8'd4, 5, 4, 16'd12, "t5_3x4");
    tick;
    mul_op(1'b0, 8'd9, 8'd0, zl, zb, 16'd0, "t5_9x0");
    tick;

    // N=8 directed and corner cases.
    mul_op(1'b1, 8'd200, 8'd150, 5, 4, 16'd30000, "t6_200x150");
    tick;
    mul_op(1'b1, 8'd255, 8'd255, 5, 4, 16'd65025, "t6_255x255");
    tick;
    check("t6_p_hold", 32'(p8), 32'd65025);

    // Random sweep against the plain product.
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      if (i % 97 == 0) x = 8'd0;
      if (i % 89 == 0) y = 8'd0;
      e = 16'(x) * 16'(y);
      if ((x == 8'd0) || (y == 8'd0)) begin
        mul_op(1'b1, x, y, zl, zb, e, "t6_sweep_zero");
      end else begin
        mul_op(1'b1, x, y, 5, 4, e, "t6_sweep");
      end
      if (i % 3 != 0) tick;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
